// File: rtl/fetch_unit.sv
// Instruction-fetch stage for the single-cycle RV32I core.
// Owns the PC, fetches over a ready handshake, holds the fetched word for one
// execute cycle, then selects the next PC from the control unit's PCSrc.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  input  logic        stall,
  output logic        fault,
  output logic [31:0] retire_count
);

  typedef enum logic [1:0] {StIdle, StReq, StExec, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        instr_valid_q;
  logic        imem_req_q;
  logic        fault_q;
  logic [31:0] retire_q;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign pc_plus4     = pc_q + 32'd4;
  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign Instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign PC           = pc_q;
  assign PCPlus4      = pc_plus4;
  assign fault        = fault_q;
  assign retire_count = retire_q;

  // Next-PC candidate; PCSrc may depend on Instr in the same cycle.
  always_comb begin
    target = pc_plus4;
    unique case (PCSrc)
      2'b01:   target = pc_q + ImmExt;
      2'b10:   target = ALUResult & ~32'h1;
      default: target = pc_plus4;
    endcase
  end

  // Fetch FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      fault_q       <= 1'b0;
      retire_q      <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q    <= StReq;
          imem_req_q <= 1'b1;
        end
        StReq: begin
          if (imem_ready) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= StExec;
          end
        end
        StExec: begin
          // Stall wins over fault detection: nothing moves while held.
          if (!stall) begin
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            if (target[1]) begin
              fault_q <= 1'b1;
              state_q <= StHalt;
            end else begin
              pc_q       <= target;
              retire_q   <= retire_q + 32'd1;
              imem_req_q <= 1'b1;
              state_q    <= StReq;
            end
          end
        end
        StHalt: begin
          // Only reset leaves HALT.
          state_q <= StHalt;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
